crc_appender: RTL

- Sits directly downstream of the serial bitstream encoder and upstream of the bit-stuffer/NRZI stage.
- Passes the encoder's serial packet bits through with zero latency and parses the PID.
- Computes CRC5 over token fields or CRC16 over data payload, then appends the complemented CRC serially.
- Back-pressures the encoder with pause_out while the CRC is being appended.

---
 rtl/crc_appender.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/crc_appender.sv
// Serial CRC5/CRC16 appender: passes packet bits through untouched,
// then shifts out the complemented CRC while holding off the encoder.
module crc_appender #(
  parameter int TOKEN_BITS = 11,
  parameter int DATA_BITS  = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  input  logic in_valid,
  output logic pause_out,
  output logic out_bit,
  output logic out_valid,
  input  logic pause_in,
  output logic busy,
  output logic pkt_done,
  output logic err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PID   = 3'd1;
  localparam logic [2:0] S_TOKEN = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CRC   = 3'd4;

  localparam logic [6:0] TOK_LAST = 7'(TOKEN_BITS - 1);
  localparam logic [6:0] DAT_LAST = 7'(DATA_BITS - 1);

  localparam logic [4:0]  POLY5  = 5'b00101;
  localparam logic [15:0] POLY16 = 16'h8005;

  logic [2:0]  state;
  logic [6:0]  cnt;
  logic [4:0]  crc_cnt;
  logic [7:0]  pid_sr;
  logic [4:0]  crc5;
  logic [15:0] crc16;
  logic        is_data;
  logic        done_q;
  logic        err_q;

  logic        in_crc;
  logic        crc_bit;
  logic [4:0]  crc_idx;
  logic        in_xfer;
  logic        trunc;
  logic [7:0]  pid_nx;
  logic        chk_ok;
  logic        fb5;
  logic        fb16;
  logic [4:0]  crc5_nx;
  logic [15:0] crc16_nx;

  assign in_crc  = (state == S_CRC);
  assign crc_idx = crc_cnt - 5'd1;
  assign crc_bit = is_data ? ~crc16[crc_idx[3:0]]
                           : ~crc5[crc_idx[2:0]];

  // Outputs are forced low while reset is held.
  assign out_valid = !rst && (in_crc | in_valid);
  assign out_bit   = !rst && (in_crc ? crc_bit : in_bit);
  assign pause_out = !rst && (in_crc | pause_in);
  assign busy      = (state != S_IDLE);
  assign pkt_done  = done_q;
  assign err       = err_q;

  assign in_xfer = in_valid && !pause_out;
  assign trunc   = !in_valid && !pause_out;

  assign pid_nx = {pid_sr[6:0], in_bit};
  assign chk_ok = (pid_nx[7:4] == ~pid_nx[3:0]);

  assign fb5      = in_bit ^ crc5[4];
  assign crc5_nx  = {crc5[3:0], 1'b0} ^ (fb5 ? POLY5 : 5'd0);
  assign fb16     = in_bit ^ crc16[15];
  assign crc16_nx = {crc16[14:0], 1'b0}
                  ^ (fb16 ? POLY16 : 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 7'd0;
      crc_cnt <= 5'd0;
      pid_sr  <= 8'd0;
      crc5    <= 5'h1F;
      crc16   <= 16'hFFFF;
      is_data <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_xfer) begin
            state  <= S_PID;
            cnt    <= 7'd1;
            pid_sr <= pid_nx;
          end
        end
        S_PID: begin
          if (in_xfer) begin
            pid_sr <= pid_nx;
            if (cnt == 7'd7) begin
              cnt <= 7'd0;
              if (!chk_ok) begin
                err_q <= 1'b1;
                state <= S_IDLE;
              end else begin
                case (pid_nx[3:0])
                  4'b0001, 4'b1001: begin
                    state   <= S_TOKEN;
                    crc5    <= 5'h1F;
                    is_data <= 1'b0;
                  end
                  4'b0011: begin
                    state   <= S_DATA;
                    crc16   <= 16'hFFFF;
                    is_data <= 1'b1;
                  end
                  4'b0010, 4'b1010: begin
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                  end
                  default: begin
                    err_q  <= 1'b1;
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                  end
                endcase
              end
            end else begin
              cnt <= cnt + 7'd1;
            end
          end else if (trunc) begin
            err_q <= 1'b1;
            state <= S_IDLE;
            cnt   <= 7'd0;
          end
        end
        S_TOKEN: begin
          if (in_xfer) begin
            crc5 <= crc5_nx;
            if (cnt == TOK_LAST) begin
              cnt     <= 7'd0;
              crc_cnt <= 5'd5;
              state   <= S_CRC;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end else if (trunc) begin
            err_q <= 1'b1;
            state <= S_IDLE;
            cnt   <= 7'd0;
          end
        end
        S_DATA: begin
          if (in_xfer) begin
            crc16 <= crc16_nx;
            if (cnt == DAT_LAST) begin
              cnt     <= 7'd0;
              crc_cnt <= 5'd16;
              state   <= S_CRC;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end else if (trunc) begin
            err_q <= 1'b1;
            state <= S_IDLE;
            cnt   <= 7'd0;
          end
        end
        S_CRC: begin
          if (!pause_in) begin
            if (crc_cnt == 5'd1) begin
              done_q  <= 1'b1;
              crc_cnt <= 5'd0;
              state   <= S_IDLE;
            end else begin
              crc_cnt <= crc_cnt - 5'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
